// File: rtl/ble_ahb_fetch_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the BLE PHY FIFO fetch master.
package ble_ahb_fetch_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HBURST_INCR = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_DRAIN,
    ST_FLUSH,
    ST_ABORT
  } state_e;

  // A beat landing on a 1 KB boundary must restart the burst as NONSEQ.
  function automatic logic [1:0] beat_trans(input logic [31:0] addr);
    return (addr[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
  endfunction

endpackage

// File: rtl/ble_ahb_fetch_master_if.sv
// AHB-Lite read bus plus PHY FIFO write port driven by the fetch master.
interface ble_ahb_fetch_master_if #(
  parameter int AD = 10
);
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic          hwrite;
  logic          hready;
  logic          hresp;
  logic [31:0]   hrdata;
  logic          fifo_write_en;
  logic [AD-3:0] fifo_address;
  logic [31:0]   fifo_write_data;

  modport master (
    output haddr, htrans, hsize, hburst, hwrite,
    output fifo_write_en, fifo_address, fifo_write_data,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hsize, hburst, hwrite,
    input  fifo_write_en, fifo_address, fifo_write_data,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ble_ahb_fetch_master.sv
// AHB-Lite INCR word-burst reader that copies a memory block into the BLE PHY FIFO.
module ble_ahb_fetch_master
  import ble_ahb_fetch_master_pkg::*;
#(
  parameter int AD = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [AD-3:0]        fifo_base,
  input  logic [AD-2:0]        word_count,
  ble_ahb_fetch_master_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [AD-2:0] LEFT_ONE = 1;
  localparam logic [AD-3:0] PTR_ONE  = 1;

  state_e        state_q, state_d;
  logic [31:0]   haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          fifo_we_q, fifo_we_d;
  logic [AD-3:0] fifo_addr_q, fifo_addr_d;
  logic [31:0]   fifo_wdata_q, fifo_wdata_d;
  logic [AD-3:0] fifo_ptr_q, fifo_ptr_d;
  logic [AD-2:0] addr_left_q, addr_left_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [31:0]   next_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      haddr_q      <= '0;
      htrans_q     <= HTRANS_IDLE;
      fifo_we_q    <= 1'b0;
      fifo_addr_q  <= '0;
      fifo_wdata_q <= '0;
      fifo_ptr_q   <= '0;
      addr_left_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      fifo_we_q    <= fifo_we_d;
      fifo_addr_q  <= fifo_addr_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_ptr_q   <= fifo_ptr_d;
      addr_left_q  <= addr_left_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign next_addr = haddr_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    fifo_we_d    = 1'b0;
    fifo_addr_d  = fifo_addr_q;
    fifo_wdata_d = fifo_wdata_q;
    fifo_ptr_d   = fifo_ptr_q;
    addr_left_d  = addr_left_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;

    unique case (state_q)
      ST_IDLE: begin
        // done_q high means a burst just finished; a start in that cycle is dropped.
        if (start && !done_q) begin
          error_d = 1'b0;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_ADDR;
            busy_d      = 1'b1;
            haddr_d     = src_addr;
            htrans_d    = HTRANS_NONSEQ;
            fifo_ptr_d  = fifo_base;
            addr_left_d = word_count;
          end
        end
      end

      ST_ADDR, ST_BURST, ST_DRAIN: begin
        if (bus.hready) begin
          if (state_q != ST_ADDR) begin
            fifo_we_d    = 1'b1;
            fifo_addr_d  = fifo_ptr_q;
            fifo_wdata_d = bus.hrdata;
            fifo_ptr_d   = fifo_ptr_q + PTR_ONE;
          end
          if (state_q == ST_DRAIN) begin
            state_d = ST_FLUSH;
          end else begin
            addr_left_d = addr_left_q - LEFT_ONE;
            if (addr_left_q > LEFT_ONE) begin
              state_d  = ST_BURST;
              haddr_d  = next_addr;
              htrans_d = beat_trans(next_addr);
            end else begin
              state_d  = ST_DRAIN;
              htrans_d = HTRANS_IDLE;
            end
          end
        end else if (bus.hresp && state_q != ST_ADDR) begin
          // First cycle of a two-cycle ERROR response: cancel the pending beat.
          state_d  = ST_ABORT;
          htrans_d = HTRANS_IDLE;
          error_d  = 1'b1;
          busy_d   = 1'b0;
        end
      end

      ST_FLUSH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ABORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.haddr           = haddr_q;
  assign bus.htrans          = htrans_q;
  assign bus.hsize           = HSIZE_WORD;
  assign bus.hburst          = HBURST_INCR;
  assign bus.hwrite          = 1'b0;
  assign bus.fifo_write_en   = fifo_we_q;
  assign bus.fifo_address    = fifo_addr_q;
  assign bus.fifo_write_data = fifo_wdata_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;

endmodule
